eeprom_test_sequencer: RTL and testbench
========================================

// Module: eeprom_test_sequencer
// PURPOSE
//  Transaction sequencer driving the I2C EEPROM controller request interface. On go: writes BYTE_CNT bytes
//  (pattern = addr[7:0] ^ SEED) from START_ADDR, one byte per I2C transaction with tWR wait, then reads all back
//  and compares. Reports pass/fail, mismatch count, first failing address; detects NACK/hung transactions by timeout.
// PARAMETERS
//  DEV_ADDR      7'h50    7-bit EEPROM slave address; wr_dev={DEV_ADDR,1'b0}, rd_dev={DEV_ADDR,1'b1}
//  START_ADDR    16'h0000 first memory address
//  BYTE_CNT      16       bytes per pass, 1..65536
//  SEED          8'hA5    data pattern XOR seed
//  TWR_CYCLES    250000   post-write wait, clk cycles (5 ms @ 50 MHz)
//  TIMEOUT_CYCLES 100000  max clk cycles from i2c_start to i2c_done
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous active-low reset
//  go           in   1   start test pass; sampled only in IDLE
//  i2c_done     in   1   controller 1-cycle completion pulse
//  rd_byte      in   8   byte read by controller; valid in i2c_done cycle when rd_flag=1
//  i2c_start    out  1   1-cycle transaction request to controller
//  rd_flag      out  1   0=write transaction, 1=random read
//  wr_dev       out  8   write control byte (constant)
//  rd_dev       out  8   read control byte (constant)
//  addh         out  8   memory address [15:8]
//  addl         out  8   memory address [7:0]
//  wr_data      out  8   write byte
//  busy         out  1   high from go accept until done or error
//  done         out  1   1-cycle pulse at end of pass (also after error)
//  pass         out  1   valid with done: 1 = no mismatch and no timeout; held until next go
//  timeout_err  out  1   sticky: transaction exceeded TIMEOUT_CYCLES; cleared on go
//  mismatch_cnt out  8   saturating count of compare failures; cleared on go
//  fail_addr    out  16  address of first mismatch; 16'h0000 if none; cleared on go
// BEHAVIOUR
//  - Reset: all outputs 0 except wr_dev/rd_dev (constants); state IDLE; counters 0. Reset mid-transaction
//    aborts with no further i2c_start; controller state is not cleared by this block.
//  - States: IDLE -> WR_REQ -> WR_WAIT -> WR_DLY -> (WR_REQ | RD_REQ) ; RD_REQ -> RD_WAIT -> CMP -> (RD_REQ | FIN);
//    any *_WAIT timeout -> ERR -> FIN; FIN -> IDLE.
//  - IDLE: go=1 -> clear status, addr<=START_ADDR, idx<=0, busy<=1, next WR_REQ. go while busy ignored.
//  - *_REQ: drive addh/addl/wr_data/rd_flag, assert i2c_start exactly 1 cycle, start timeout counter.
//    addh/addl/wr_data/rd_flag held stable from i2c_start until i2c_done.
//  - *_WAIT: i2c_done=1 -> proceed; counter==TIMEOUT_CYCLES-1 without done -> timeout path.
//    i2c_done in any other state is ignored.
//  - WR_DLY: count TWR_CYCLES, then idx+1; idx==BYTE_CNT-1 -> reset addr/idx, go RD_REQ.
//  - RD_WAIT: rd_byte sampled in i2c_done cycle; CMP next cycle: rd_byte != addr[7:0]^SEED ->
//    mismatch_cnt+1 (saturate 255); fail_addr<=addr on first mismatch only.
//  - Address arithmetic mod 2^16: START_ADDR+idx wraps 16'hFFFF -> 16'h0000.
//  - FIN: busy<=0, done pulse 1 cycle, pass<=(mismatch_cnt==0)&&!timeout_err. Pass latency (no errors):
//    BYTE_CNT*(2 transactions + TWR_CYCLES) + small fixed overhead.
// CONFIGURATION
//  EEPROM_RETRY_EN defined: on timeout reissue same transaction (same addr/data) up to 3 retries;
//    timeout_err set and ERR entered only after 4th consecutive timeout; retry counter resets per byte.
//  Not defined: first timeout sets timeout_err, enters ERR, ends pass (done pulse, pass=0).
// TESTING
//  1. BYTE_CNT=4, START_ADDR=16'h0010, model echoes written data -> 4 writes then 4 reads, addl 10..13,
//     wr_data B5,B4,B7,B6; done with pass=1, mismatch_cnt=0, fail_addr=0.
//  2. Model corrupts read of 16'h0012 (returns 00) -> pass=0, mismatch_cnt=1, fail_addr=16'h0012.
//  3. Model never returns i2c_done on 2nd write -> no retry build: timeout_err=1, done after TIMEOUT_CYCLES,
//     pass=0; EEPROM_RETRY_EN build: exactly 4 i2c_start pulses for that addr before error.
//  4. START_ADDR=16'hFFFE, BYTE_CNT=4 -> addresses FFFE,FFFF,0000,0001; pass=1.
//  5. go pulses during busy and spurious i2c_done in WR_DLY -> ignored; sequence and timing unchanged.
//  6. rst_n low for 1 cycle during RD_WAIT -> next cycle all outputs 0, IDLE; subsequent go runs clean pass.

Source files
------------

// File: rtl/eeprom_test_sequencer.sv
// ---------------------------------------------------------------------------
// eeprom_test_sequencer
//
// Purpose:
//   Drives the request interface of an I2C EEPROM controller to run one
//   write/read-back test pass. On go it writes BYTE_CNT bytes starting at
//   START_ADDR. Each byte uses one I2C transaction and carries the pattern
//   addr[7:0] ^ SEED, and each write is followed by a TWR_CYCLES wait. It then
//   reads every byte back and compares it with the pattern. It reports
//   pass/fail, a saturating mismatch count and the first failing address.
//   A transaction that gets no i2c_done_i within TIMEOUT_CYCLES counts as a
//   timeout (NACK / hung bus).
//
// Optional feature (macro EEPROM_RETRY_EN):
//   When defined, a timed-out transaction is reissued (same address and
//   data) up to 3 times. timeout_err_o is raised only after the 4th
//   consecutive timeout. The retry count restarts for every byte.
//   When undefined, the first timeout ends the pass with pass_o = 0.
//
// Ports:
//   clk_i           system clock
//   rst_n_i         synchronous active-low reset
//   go_i            start a test pass (only sampled while idle)
//   i2c_done_i      one-cycle completion pulse from the controller
//   rd_byte_i       read data, valid with i2c_done_i on a read
//   i2c_start_o     one-cycle transaction request
//   rd_flag_o       0 = write transaction, 1 = random read
//   wr_dev_o        write control byte {DEV_ADDR, 0}
//   rd_dev_o        read control byte  {DEV_ADDR, 1}
//   addh_o, addl_o  memory address high / low byte
//   wr_data_o       byte to write
//   busy_o          high from go accept until the pass ends
//   done_o          one-cycle pulse at the end of a pass
//   pass_o          result of the last pass, held until next go
//   timeout_err_o   sticky timeout flag, cleared on go
//   mismatch_cnt_o  saturating compare-failure count, cleared on go
//   fail_addr_o     address of the first mismatch, cleared on go
// ---------------------------------------------------------------------------
module eeprom_test_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter logic [15:0] START_ADDR     = 16'h0000,
  parameter int unsigned BYTE_CNT       = 32'd16,
  parameter logic [7:0]  SEED           = 8'hA5,
  parameter int unsigned TWR_CYCLES     = 32'd250000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        go_i,
  input  logic        i2c_done_i,
  input  logic [7:0]  rd_byte_i,
  output logic        i2c_start_o,
  output logic        rd_flag_o,
  output logic [7:0]  wr_dev_o,
  output logic [7:0]  rd_dev_o,
  output logic [7:0]  addh_o,
  output logic [7:0]  addl_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_err_o,
  output logic [7:0]  mismatch_cnt_o,
  output logic [15:0] fail_addr_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_REQ  = 4'd1,
    S_WR_WAIT = 4'd2,
    S_WR_DLY  = 4'd3,
    S_RD_REQ  = 4'd4,
    S_RD_WAIT = 4'd5,
    S_CMP     = 4'd6,
    S_ERR     = 4'd7,
    S_FIN     = 4'd8
  } state_e;

  // BYTE_CNT may be 65536, so the last index is what is kept, not the count.
  localparam logic [15:0] LAST_IDX = 16'(BYTE_CNT - 32'd1);
  localparam logic [31:0] TWR_LAST = 32'(TWR_CYCLES - 32'd1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] idx_q, idx_d;
  // The timeout count (in *_WAIT) and the tWR count (in WR_DLY) are never
  // needed together, so one counter serves both.
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic        start_q, start_d;
  logic        rd_flag_q, rd_flag_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tmo_err_q, tmo_err_d;
  logic [7:0]  mm_cnt_q, mm_cnt_d;
  logic [15:0] fail_addr_q, fail_addr_d;
  logic        tmo_hit_s;
`ifdef EEPROM_RETRY_EN
  logic [1:0]  retry_q, retry_d;
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'h0000;
      idx_q       <= 16'h0000;
      cnt_q       <= 32'd0;
      rd_byte_q   <= 8'h00;
      start_q     <= 1'b0;
      rd_flag_q   <= 1'b0;
      wr_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      mm_cnt_q    <= 8'h00;
      fail_addr_q <= 16'h0000;
`ifdef EEPROM_RETRY_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rd_byte_q   <= rd_byte_d;
      start_q     <= start_d;
      rd_flag_q   <= rd_flag_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tmo_err_q   <= tmo_err_d;
      mm_cnt_q    <= mm_cnt_d;
      fail_addr_q <= fail_addr_d;
`ifdef EEPROM_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  // Next-state and next-output logic for the test sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rd_byte_d   = rd_byte_q;
    start_d     = 1'b0;
    rd_flag_d   = rd_flag_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    tmo_err_d   = tmo_err_q;
    mm_cnt_d    = mm_cnt_q;
    fail_addr_d = fail_addr_q;
    tmo_hit_s   = 1'b0;
`ifdef EEPROM_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          tmo_err_d   = 1'b0;
          mm_cnt_d    = 8'h00;
          fail_addr_d = 16'h0000;
          addr_d      = START_ADDR;
          idx_d       = 16'h0000;
`ifdef EEPROM_RETRY_EN
          retry_d     = 2'd0;
`endif
          state_d     = S_WR_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end

      // Request fields are registered here and stay put through *_WAIT.
      S_WR_REQ: begin
        start_d   = 1'b1;
        rd_flag_d = 1'b0;
        wr_data_d = addr_q[7:0] ^ SEED;
        cnt_d     = 32'd0;
        state_d   = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        if (i2c_done_i) begin
          cnt_d   = 32'd0;
`ifdef EEPROM_RETRY_EN
          retry_d = 2'd0;
`endif
          state_d = S_WR_DLY;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_WR_DLY: begin
        if (cnt_q == TWR_LAST) begin
          cnt_d = 32'd0;
          if (idx_q == LAST_IDX) begin
            idx_d   = 16'h0000;
            addr_d  = START_ADDR;
            state_d = S_RD_REQ;
          end else begin
            idx_d   = idx_q + 16'd1;
            addr_d  = addr_q + 16'd1;
            state_d = S_WR_REQ;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_RD_REQ: begin
        start_d   = 1'b1;
        rd_flag_d = 1'b1;
        cnt_d     = 32'd0;
        state_d   = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (i2c_done_i) begin
          rd_byte_d = rd_byte_i;
`ifdef EEPROM_RETRY_EN
          retry_d   = 2'd0;
`endif
          state_d   = S_CMP;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_CMP: begin
        if (rd_byte_q != (addr_q[7:0] ^ SEED)) begin
          // A zero count means this is the first mismatch of the pass.
          if (mm_cnt_q == 8'h00) begin
            fail_addr_d = addr_q;
          end else begin
            fail_addr_d = fail_addr_q;
          end
          if (mm_cnt_q != 8'hFF) begin
            mm_cnt_d = mm_cnt_q + 8'd1;
          end else begin
            mm_cnt_d = mm_cnt_q;
          end
        end else begin
          mm_cnt_d = mm_cnt_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 16'd1;
          addr_d  = addr_q + 16'd1;
          state_d = S_RD_REQ;
        end
      end

      S_ERR: begin
        state_d = S_FIN;
      end

      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (mm_cnt_q == 8'h00) && !tmo_err_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared timeout handling for both *_WAIT states.
    if (tmo_hit_s) begin
`ifdef EEPROM_RETRY_EN
      if (retry_q == 2'd3) begin
        retry_d   = 2'd0;
        tmo_err_d = 1'b1;
        state_d   = S_ERR;
      end else begin
        retry_d = retry_q + 2'd1;
        state_d = (state_q == S_RD_WAIT) ? S_RD_REQ : S_WR_REQ;
      end
`else
      tmo_err_d = 1'b1;
      state_d   = S_ERR;
`endif
    end else begin
      cnt_d = cnt_d;
    end
  end

  assign wr_dev_o       = {DEV_ADDR, 1'b0};
  assign rd_dev_o       = {DEV_ADDR, 1'b1};
  assign i2c_start_o    = start_q;
  assign rd_flag_o      = rd_flag_q;
  assign addh_o         = addr_q[15:8];
  assign addl_o         = addr_q[7:0];
  assign wr_data_o      = wr_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign timeout_err_o  = tmo_err_q;
  assign mismatch_cnt_o = mm_cnt_q;
  assign fail_addr_o    = fail_addr_q;

endmodule

// File: tb/tb_eeprom_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_eeprom_test_sequencer
//
// Two sequencer instances share one controller model through a select mux:
// u_dut1 starts at 16'h0010 and u_dut2 starts at 16'hFFFE to exercise
// address wrap. Both use BYTE_CNT=4 and short tWR/timeout values. The model
// echoes written data. It can corrupt the read of 16'h0012 and can hang
// writes to 16'h0011.
// ---------------------------------------------------------------------------
module tb_eeprom_test_sequencer;

  localparam int TWR = 8;
  localparam int TMO = 20;
  localparam int LAT = 2;
`ifdef EEPROM_RETRY_EN
  localparam int HANG_STARTS = 5;
`else
  localparam int HANG_STARTS = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, go1, go2;
  logic done_in1, done_in2;
  logic [7:0] rdb1, rdb2;

  logic s1_start, s1_rd, s1_busy, s1_done, s1_pass, s1_tmo;
  logic [7:0] s1_wdev, s1_rdev, s1_addh, s1_addl, s1_wdata, s1_mm;
  logic [15:0] s1_fail;
  logic s2_start, s2_rd, s2_busy, s2_done, s2_pass, s2_tmo;
  logic [7:0] s2_wdev, s2_rdev, s2_addh, s2_addl, s2_wdata, s2_mm;
  logic [15:0] s2_fail;

  eeprom_test_sequencer #(.START_ADDR(16'h0010), .BYTE_CNT(32'd4),
    .TWR_CYCLES(32'd8), .TIMEOUT_CYCLES(32'd20)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .go_i(go1), .i2c_done_i(done_in1), .rd_byte_i(rdb1),
    .i2c_start_o(s1_start), .rd_flag_o(s1_rd), .wr_dev_o(s1_wdev), .rd_dev_o(s1_rdev),
    .addh_o(s1_addh), .addl_o(s1_addl), .wr_data_o(s1_wdata), .busy_o(s1_busy),
    .done_o(s1_done), .pass_o(s1_pass), .timeout_err_o(s1_tmo),
    .mismatch_cnt_o(s1_mm), .fail_addr_o(s1_fail));

  eeprom_test_sequencer #(.START_ADDR(16'hFFFE), .BYTE_CNT(32'd4),
    .TWR_CYCLES(32'd8), .TIMEOUT_CYCLES(32'd20)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .go_i(go2), .i2c_done_i(done_in2), .rd_byte_i(rdb2),
    .i2c_start_o(s2_start), .rd_flag_o(s2_rd), .wr_dev_o(s2_wdev), .rd_dev_o(s2_rdev),
    .addh_o(s2_addh), .addl_o(s2_addl), .wr_data_o(s2_wdata), .busy_o(s2_busy),
    .done_o(s2_done), .pass_o(s2_pass), .timeout_err_o(s2_tmo),
    .mismatch_cnt_o(s2_mm), .fail_addr_o(s2_fail));

  // Controller model and its mux onto the selected instance.
  bit sel2 = 1'b0;
  logic m_done = 1'b0;
  logic [7:0] m_rdbyte = 8'h00;
  logic m_start, m_rd;
  logic [7:0] m_addh, m_addl, m_wdata;
  assign m_start  = sel2 ? s2_start : s1_start;
  assign m_rd     = sel2 ? s2_rd    : s1_rd;
  assign m_addh   = sel2 ? s2_addh  : s1_addh;
  assign m_addl   = sel2 ? s2_addl  : s1_addl;
  assign m_wdata  = sel2 ? s2_wdata : s1_wdata;
  assign done_in1 = sel2 ? 1'b0 : m_done;
  assign done_in2 = sel2 ? m_done : 1'b0;
  assign rdb1     = m_rdbyte;
  assign rdb2     = m_rdbyte;

  int checks = 0;
  int errors = 0;
  bit corrupt_en = 1'b0, hang_en = 1'b0, spur_en = 1'b0;
  bit pend = 1'b0;
  int lat = 0;
  int since_w = 100;
  logic [15:0] p_addr;
  logic p_rd;
  logic [7:0] p_wd;
  logic [7:0] mem [0:255];
  logic [15:0] log_addr [0:31];
  logic log_rd [0:31];
  logic [7:0] log_wd [0:31];
  int n_log = 0;

  always @(negedge clk) begin
    m_done = 1'b0;
    m_rdbyte = 8'h00;
    since_w = since_w + 1;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (m_start) begin
      if (n_log < 32) begin
        log_addr[n_log] = {m_addh, m_addl};
        log_rd[n_log] = m_rd;
        log_wd[n_log] = m_wdata;
      end
      n_log = n_log + 1;
      p_addr = {m_addh, m_addl};
      p_rd = m_rd;
      p_wd = m_wdata;
      lat = LAT;
      pend = !(hang_en && !m_rd && ({m_addh, m_addl} == 16'h0011));
    end else if (pend) begin
      checks++;
      if ({m_addh, m_addl, m_wdata, m_rd} !== {p_addr, p_wd, p_rd}) begin
        errors++;
        $display("FAIL hold_stable: got %h expected %h", {m_addh, m_addl, m_wdata, m_rd}, {p_addr, p_wd, p_rd});
      end
      if (lat == 0) begin
        m_done = 1'b1;
        pend = 1'b0;
        if (p_rd) begin
          m_rdbyte = (corrupt_en && p_addr == 16'h0012) ? 8'h00 : mem[p_addr[7:0]];
        end else begin
          mem[p_addr[7:0]] = p_wd;
          since_w = 0;
        end
      end else begin
        lat = lat - 1;
      end
    end
    // Stray completion three cycles after a write finished, i.e. in WR_DLY.
    if (spur_en && since_w == 3) m_done = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse go, then wait (bounded) for done; cyc counts negedges since go.
  task automatic run(input bit use2, input bit extra_go, output int cyc, output int last_s, output bit ok);
    sel2 = use2;
    n_log = 0;
    @(negedge clk);
    if (use2) go2 = 1'b1; else go1 = 1'b1;
    cyc = 0;
    last_s = -1;
    ok = 1'b0;
    while (!ok && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      go1 = 1'b0;
      go2 = 1'b0;
      if (extra_go && (cyc == 5 || cyc == 30 || cyc == 60)) go1 = 1'b1;
      if (use2 ? s2_start : s1_start) last_s = cyc;
      if (use2 ? s2_done : s1_done) ok = 1'b1;
    end
    go1 = 1'b0;
    go2 = 1'b0;
    chk("done_seen", {63'd0, ok}, 64'd1);
  endtask

  typedef struct {
    bit corrupt;
    bit hang;
    bit exp_pass;
    bit exp_tmo;
    logic [7:0] exp_mm;
    logic [15:0] exp_fail;
    int exp_starts;
  } vec_t;

  vec_t vt [3];
  logic [7:0] exp_wr1 [4];
  logic [15:0] exp_a2 [4];
  logic [7:0] exp_wr2 [4];
  int cyc, cyc_base, last_s, idx;
  bit ok;

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000, 8};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'h0012, 8};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 16'h0000, HANG_STARTS};
    exp_wr1 = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    exp_a2  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_wr2 = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    cyc_base = 0;

    rst_n = 1'b0;
    go1 = 1'b0;
    go2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {10'd0, s1_start, s1_rd, s1_addh, s1_addl, s1_wdata, s1_busy, s1_done, s1_pass, s1_tmo, s1_mm, s1_fail}, 64'd0);
    chk("wr_dev", {56'd0, s1_wdev}, 64'hA0);
    chk("rd_dev", {56'd0, s1_rdev}, 64'hA1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven passes on u_dut1: clean, corrupted read, hung write.
    for (int v = 0; v < 3; v++) begin
      corrupt_en = vt[v].corrupt;
      hang_en = vt[v].hang;
      run(1'b0, 1'b0, cyc, last_s, ok);
      if (v == 0) cyc_base = cyc;
      chk("pass", {63'd0, s1_pass}, {63'd0, vt[v].exp_pass});
      chk("timeout_err", {63'd0, s1_tmo}, {63'd0, vt[v].exp_tmo});
      chk("mismatch_cnt", {56'd0, s1_mm}, {56'd0, vt[v].exp_mm});
      chk("fail_addr", {48'd0, s1_fail}, {48'd0, vt[v].exp_fail});
      chk("busy_at_done", {63'd0, s1_busy}, 64'd0);
      chk("start_count", 64'(n_log), 64'(vt[v].exp_starts));
      for (int i = 0; i < vt[v].exp_starts && i < n_log; i++) begin
        idx = vt[v].hang ? ((i == 0) ? 0 : 1) : (i % 4);
        chk("seq_addr", {48'd0, log_addr[i]}, {48'd0, 16'h0010 + 16'(idx)});
        chk("seq_rd_flag", {63'd0, log_rd[i]}, {63'd0, (!vt[v].hang && i >= 4)});
        if (!log_rd[i]) chk("seq_wr_data", {56'd0, log_wd[i]}, {56'd0, exp_wr1[idx]});
      end
      if (vt[v].hang) begin
        chk("timeout_latency_min", {63'd0, (cyc - last_s) >= TMO}, 64'd1);
        chk("timeout_latency_max", {63'd0, (cyc - last_s) <= TMO + 4}, 64'd1);
      end
      @(negedge clk);
      chk("done_one_cycle", {63'd0, s1_done}, 64'd0);
      chk("pass_held", {63'd0, s1_pass}, {63'd0, vt[v].exp_pass});
      corrupt_en = 1'b0;
      hang_en = 1'b0;
      repeat (2) @(negedge clk);
    end

    // go while busy and a stray i2c_done in WR_DLY change nothing.
    spur_en = 1'b1;
    run(1'b0, 1'b1, cyc, last_s, ok);
    spur_en = 1'b0;
    chk("ignore_same_timing", 64'(cyc), 64'(cyc_base));
    chk("ignore_pass", {63'd0, s1_pass}, 64'd1);
    chk("ignore_starts", 64'(n_log), 64'd8);
    repeat (2) @(negedge clk);

    // Address wrap FFFE..0001 on u_dut2.
    run(1'b1, 1'b0, cyc, last_s, ok);
    chk("wrap_pass", {63'd0, s2_pass}, 64'd1);
    chk("wrap_starts", 64'(n_log), 64'd8);
    for (int i = 0; i < 8 && i < n_log; i++) begin
      chk("wrap_addr", {48'd0, log_addr[i]}, {48'd0, exp_a2[i % 4]});
      chk("wrap_rd_flag", {63'd0, log_rd[i]}, {63'd0, i >= 4});
      if (i < 4) chk("wrap_wr_data", {56'd0, log_wd[i]}, {56'd0, exp_wr2[i]});
    end
    repeat (2) @(negedge clk);

    // One-cycle reset during RD_WAIT, then a clean pass.
    sel2 = 1'b0;
    n_log = 0;
    go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    cyc = 0;
    while (!(s1_start && s1_rd) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_rd_wait", {63'd0, s1_start && s1_rd}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset_outputs", {10'd0, s1_start, s1_rd, s1_addh, s1_addl, s1_wdata, s1_busy, s1_done, s1_pass, s1_tmo, s1_mm, s1_fail}, 64'd0);
    rst_n = 1'b1;
    n_log = 0;
    repeat (5) @(negedge clk);
    chk("no_start_after_reset", 64'(n_log), 64'd0);
    run(1'b0, 1'b0, cyc, last_s, ok);
    chk("post_reset_pass", {63'd0, s1_pass}, 64'd1);
    chk("post_reset_starts", 64'(n_log), 64'd8);
    chk("post_reset_timing", 64'(cyc), 64'(cyc_base));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
